scr1_tcm_banked: RTL and testbench



---
 rtl/scr1_tcm_pkg.sv | 71 +++++++
 rtl/scr1_tcm_bank.sv | 32 +++
 rtl/scr1_tcm_banked.sv | 173 +++++++++++++++++
 tb/tb_scr1_tcm_banked.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/scr1_tcm_pkg.sv
// Shared types and helpers for the banked TCM.
// Contents: bus widths, memory command/width/response enums, response-pipeline
// entry, default geometry with derived index widths, and the write-lane helper
// that builds byte enables and replicated write data.
package scr1_tcm_pkg;

  localparam int SCR1_IMEM_AWIDTH = 32;
  localparam int SCR1_IMEM_DWIDTH = 32;
  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_DMEM_DWIDTH = 32;

  // Default geometry; instances may override through module parameters.
  localparam int SCR1_TCM_SIZE_DFLT  = 32'h0001_0000;
  localparam int SCR1_TCM_BANKS_DFLT = 2;
  localparam int SCR1_TCM_BIDX_W     = (SCR1_TCM_BANKS_DFLT > 1) ? $clog2(SCR1_TCM_BANKS_DFLT) : 1;
  localparam int SCR1_TCM_WIDX_W     = $clog2(SCR1_TCM_SIZE_DFLT / 4 / SCR1_TCM_BANKS_DFLT);

  typedef enum logic {
    SCR1_MEM_CMD_RD,
    SCR1_MEM_CMD_WR
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE,
    SCR1_MEM_WIDTH_HWORD,
    SCR1_MEM_WIDTH_WORD
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY,
    SCR1_MEM_RESP_RDY_OK,
    SCR1_MEM_RESP_RDY_ER
  } type_scr1_mem_resp_e;

  typedef struct packed {
    logic       valid;
    logic       err;
    logic [1:0] offs;
  } type_scr1_tcm_pipe_s;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
  } type_scr1_tcm_wr_s;

  // Sub-word stores replicate the payload across the word so the byte enables
  // alone select the target lanes.
  function automatic type_scr1_tcm_wr_s scr1_tcm_wr_prep(
    input type_scr1_mem_width_e width,
    input logic [1:0]           offs,
    input logic [31:0]          wdata
  );
    type_scr1_tcm_wr_s r;
    case (width)
      SCR1_MEM_WIDTH_BYTE: begin
        r.be   = 4'b0001 << offs;
        r.data = {4{wdata[7:0]}};
      end
      SCR1_MEM_WIDTH_HWORD: begin
        r.be   = 4'b0011 << {offs[1], 1'b0};
        r.data = {2{wdata[15:0]}};
      end
      default: begin
        r.be   = 4'b1111;
        r.data = wdata;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/scr1_tcm_bank.sv
// Single-port synchronous SRAM model with per-byte write enable.
// Ports: clk; en (access strobe); we (1 = write, 0 = read); be (byte enables);
// addr (word index); wdata; rdata (registered, updated only on read accesses).
// Contents are not reset.
module scr1_tcm_bank #(
  parameter int SCR1_WIDTH = 32,
  parameter int SCR1_DEPTH = 8192
) (
  input  logic                          clk,
  input  logic                          en,
  input  logic                          we,
  input  logic [SCR1_WIDTH/8-1:0]       be,
  input  logic [$clog2(SCR1_DEPTH)-1:0] addr,
  input  logic [SCR1_WIDTH-1:0]         wdata,
  output logic [SCR1_WIDTH-1:0]         rdata
);

  logic [SCR1_WIDTH-1:0] mem [SCR1_DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < SCR1_WIDTH / 8; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/scr1_tcm_banked.sv
// Word-interleaved multi-bank TCM serving the core imem and dmem ports.
// Ports: clk, rst (synchronous, active-high);
//   imem: imem_req/imem_addr in, imem_req_ack/imem_rdata/imem_resp out;
//   dmem: dmem_req/dmem_cmd/dmem_width/dmem_addr/dmem_wdata in,
//         dmem_req_ack/dmem_rdata/dmem_resp out.
// Same-bank requests are arbitrated by a priority flag that passes to the loser;
// out-of-window or misaligned requests are accepted and answered with an error.
module scr1_tcm_banked
  import scr1_tcm_pkg::*;
#(
  parameter logic [SCR1_IMEM_AWIDTH-1:0] SCR1_TCM_BASE   = 32'h0048_0000,
  parameter logic [SCR1_IMEM_AWIDTH-1:0] SCR1_TCM_SIZE   = SCR1_TCM_SIZE_DFLT,
  parameter int                          SCR1_TCM_BANKS  = SCR1_TCM_BANKS_DFLT,
  parameter int                          SCR1_TCM_RD_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        imem_req_ack,
  input  logic                        imem_req,
  input  logic [SCR1_IMEM_AWIDTH-1:0] imem_addr,
  output logic [SCR1_IMEM_DWIDTH-1:0] imem_rdata,
  output type_scr1_mem_resp_e         imem_resp,
  output logic                        dmem_req_ack,
  input  logic                        dmem_req,
  input  type_scr1_mem_cmd_e          dmem_cmd,
  input  type_scr1_mem_width_e        dmem_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
  input  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata,
  output logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata,
  output type_scr1_mem_resp_e         dmem_resp
);

  localparam int AW      = SCR1_IMEM_AWIDTH;
  localparam int BSEL_W  = (SCR1_TCM_BANKS > 1) ? $clog2(SCR1_TCM_BANKS) : 1;
  localparam int WORDS   = int'(SCR1_TCM_SIZE) / 4 / SCR1_TCM_BANKS;
  localparam int WIDX_W  = $clog2(WORDS);
  localparam int WIDX_SH = 2 + $clog2(SCR1_TCM_BANKS);
  localparam logic [AW-1:0] WIN_MASK  = ~(SCR1_TCM_SIZE - 1'b1);
  localparam logic [AW-1:0] BSEL_MASK = AW'(SCR1_TCM_BANKS - 1);
  localparam logic [AW-1:0] WIDX_MASK = AW'(WORDS - 1);

  logic              i_err, d_err, d_mis, conflict, prio_imem, i_go, d_go;
  logic [BSEL_W-1:0] i_bank, d_bank, i_bank_q, d_bank_q;
  logic [WIDX_W-1:0] i_widx, d_widx;
  logic [31:0]       bank_rdata [SCR1_TCM_BANKS];
  logic [31:0]       i_raw, d_raw, i_ro, d_ro;
  logic              d_wr1, d_wro;
  type_scr1_tcm_pipe_s i_p1, d_p1, i_po, d_po;
  type_scr1_tcm_wr_s   d_wr_prep;

  // Masking with BANKS-1 keeps the single-bank case at bank 0 without a
  // zero-width slice.
  assign i_bank = BSEL_W'((imem_addr >> 2) & BSEL_MASK);
  assign d_bank = BSEL_W'((dmem_addr >> 2) & BSEL_MASK);
  assign i_widx = WIDX_W'((imem_addr >> WIDX_SH) & WIDX_MASK);
  assign d_widx = WIDX_W'((dmem_addr >> WIDX_SH) & WIDX_MASK);

  always_comb begin
    d_mis = 1'b0;
    case (dmem_width)
      SCR1_MEM_WIDTH_HWORD: d_mis = dmem_addr[0];
      SCR1_MEM_WIDTH_WORD:  d_mis = |dmem_addr[1:0];
      default:              d_mis = 1'b0;
    endcase
  end

  assign i_err = ((imem_addr & WIN_MASK) != SCR1_TCM_BASE) || (imem_addr[1:0] != 2'b00);
  assign d_err = ((dmem_addr & WIN_MASK) != SCR1_TCM_BASE) || d_mis;

  // Erroring requests touch no bank, so they never take part in a conflict.
  assign conflict = imem_req && dmem_req && !i_err && !d_err && (i_bank == d_bank);

  assign imem_req_ack = !rst && imem_req && (!conflict || prio_imem);
  assign dmem_req_ack = !rst && dmem_req && (!conflict || !prio_imem);
  assign i_go = imem_req_ack && !i_err;
  assign d_go = dmem_req_ack && !d_err;

  assign d_wr_prep = scr1_tcm_wr_prep(dmem_width, dmem_addr[1:0], dmem_wdata);

  for (genvar b = 0; b < SCR1_TCM_BANKS; b++) begin : g_bank
    logic sel_i, sel_d;
    assign sel_i = i_go && (i_bank == BSEL_W'(b));
    assign sel_d = d_go && (d_bank == BSEL_W'(b));

    scr1_tcm_bank #(
      .SCR1_WIDTH (32),
      .SCR1_DEPTH (WORDS)
    ) u_bank (
      .clk   (clk),
      .en    (sel_i || sel_d),
      .we    (sel_d && (dmem_cmd == SCR1_MEM_CMD_WR)),
      .be    (d_wr_prep.be),
      .addr  (sel_d ? d_widx : i_widx),
      .wdata (d_wr_prep.data),
      .rdata (bank_rdata[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_imem <= 1'b0;
      i_p1      <= '0;
      d_p1      <= '0;
      d_wr1     <= 1'b0;
    end else begin
      if (conflict) prio_imem <= ~prio_imem;
      i_p1  <= '{valid: imem_req_ack, err: i_err, offs: imem_addr[1:0]};
      d_p1  <= '{valid: dmem_req_ack, err: d_err, offs: dmem_addr[1:0]};
      d_wr1 <= (dmem_cmd == SCR1_MEM_CMD_WR);
    end
    i_bank_q <= i_bank;
    d_bank_q <= d_bank;
  end

  assign i_raw = bank_rdata[i_bank_q];
  assign d_raw = bank_rdata[d_bank_q];

  if (SCR1_TCM_RD_LAT == 2) begin : g_lat2
    type_scr1_tcm_pipe_s i_p2, d_p2;
    logic                d_wr2;
    logic [31:0]         i_raw2, d_raw2;

    always_ff @(posedge clk) begin
      if (rst) begin
        i_p2  <= '0;
        d_p2  <= '0;
        d_wr2 <= 1'b0;
      end else begin
        i_p2  <= i_p1;
        d_p2  <= d_p1;
        d_wr2 <= d_wr1;
      end
      i_raw2 <= i_raw;
      d_raw2 <= d_raw;
    end

    assign i_po  = i_p2;
    assign d_po  = d_p2;
    assign d_wro = d_wr2;
    assign i_ro  = i_raw2;
    assign d_ro  = d_raw2;
  end else begin : g_lat1
    assign i_po  = i_p1;
    assign d_po  = d_p1;
    assign d_wro = d_wr1;
    assign i_ro  = i_raw;
    assign d_ro  = d_raw;
  end

  always_comb begin
    imem_resp  = SCR1_MEM_RESP_NOTRDY;
    imem_rdata = '0;
    dmem_resp  = SCR1_MEM_RESP_NOTRDY;
    dmem_rdata = '0;
    if (i_po.valid) begin
      if (i_po.err) begin
        imem_resp = SCR1_MEM_RESP_RDY_ER;
      end else begin
        imem_resp  = SCR1_MEM_RESP_RDY_OK;
        imem_rdata = i_ro;
      end
    end
    if (d_po.valid) begin
      if (d_po.err) begin
        dmem_resp = SCR1_MEM_RESP_RDY_ER;
      end else begin
        dmem_resp = SCR1_MEM_RESP_RDY_OK;
        if (!d_wro) dmem_rdata = d_ro >> {d_po.offs, 3'b000};
      end
    end
  end

endmodule

// File: tb/tb_scr1_tcm_banked.sv
// Directed bench for scr1_tcm_banked. Two instances share all inputs: u_lat1
// (RD_LAT=1) carries the functional checks, u_lat2 (RD_LAT=2) the streaming
// and reset-flush checks. Arbitration is latency-independent, so acks come
// from u_lat1.
module tb_scr1_tcm_banked;
  import scr1_tcm_pkg::*;

  localparam logic [31:0] BASE = 32'h0048_0000;
  localparam logic [31:0] SIZE = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_req = 1'b0;
  logic [31:0] imem_addr = '0;
  logic dmem_req = 1'b0;
  type_scr1_mem_cmd_e dmem_cmd = SCR1_MEM_CMD_RD;
  type_scr1_mem_width_e dmem_width = SCR1_MEM_WIDTH_WORD;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;

  logic i1_ack, d1_ack, i2_ack, d2_ack;
  logic [31:0] i1_rdata, d1_rdata, i2_rdata, d2_rdata;
  type_scr1_mem_resp_e i1_resp, d1_resp, i2_resp, d2_resp;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  scr1_tcm_banked #(
    .SCR1_TCM_BASE (BASE), .SCR1_TCM_SIZE (SIZE),
    .SCR1_TCM_BANKS (2), .SCR1_TCM_RD_LAT (1)
  ) u_lat1 (
    .clk (clk), .rst (rst),
    .imem_req_ack (i1_ack), .imem_req (imem_req), .imem_addr (imem_addr),
    .imem_rdata (i1_rdata), .imem_resp (i1_resp),
    .dmem_req_ack (d1_ack), .dmem_req (dmem_req), .dmem_cmd (dmem_cmd),
    .dmem_width (dmem_width), .dmem_addr (dmem_addr), .dmem_wdata (dmem_wdata),
    .dmem_rdata (d1_rdata), .dmem_resp (d1_resp)
  );

  scr1_tcm_banked #(
    .SCR1_TCM_BASE (BASE), .SCR1_TCM_SIZE (SIZE),
    .SCR1_TCM_BANKS (2), .SCR1_TCM_RD_LAT (2)
  ) u_lat2 (
    .clk (clk), .rst (rst),
    .imem_req_ack (i2_ack), .imem_req (imem_req), .imem_addr (imem_addr),
    .imem_rdata (i2_rdata), .imem_resp (i2_resp),
    .dmem_req_ack (d2_ack), .dmem_req (dmem_req), .dmem_cmd (dmem_cmd),
    .dmem_width (dmem_width), .dmem_addr (dmem_addr), .dmem_wdata (dmem_wdata),
    .dmem_rdata (d2_rdata), .dmem_resp (d2_resp)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  // Single dmem transaction checked on u_lat1; returns at the response negedge.
  task automatic dm_acc(input string tag, input type_scr1_mem_cmd_e cmd,
                        input type_scr1_mem_width_e w, input logic [31:0] a,
                        input logic [31:0] wd, input type_scr1_mem_resp_e er,
                        input logic [31:0] ed);
    int k = 0;
    dmem_req = 1'b1; dmem_cmd = cmd; dmem_width = w; dmem_addr = a; dmem_wdata = wd;
    #1;
    while (!d1_ack && k < 8) begin
      @(posedge clk); #1; k++;
    end
    chk({tag, ".ack"}, 32'(d1_ack), 32'd1);
    @(posedge clk); #1 dmem_req = 1'b0;
    @(negedge clk);
    chk({tag, ".resp"}, 32'(d1_resp), 32'(er));
    chk({tag, ".rdata"}, d1_rdata, ed);
  endtask

  task automatic im_acc(input string tag, input logic [31:0] a,
                        input type_scr1_mem_resp_e er, input logic [31:0] ed);
    int k = 0;
    imem_req = 1'b1; imem_addr = a;
    #1;
    while (!i1_ack && k < 8) begin
      @(posedge clk); #1; k++;
    end
    chk({tag, ".ack"}, 32'(i1_ack), 32'd1);
    @(posedge clk); #1 imem_req = 1'b0;
    @(negedge clk);
    chk({tag, ".resp"}, 32'(i1_resp), 32'(er));
    chk({tag, ".rdata"}, i1_rdata, ed);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: requests pending but not acknowledged.
    imem_req = 1'b1; imem_addr = BASE; dmem_req = 1'b1;
    dmem_cmd = SCR1_MEM_CMD_WR; dmem_addr = BASE + 32'h4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.i_ack", 32'(i1_ack), 32'd0);
    chk("rst.d_ack", 32'(d1_ack), 32'd0);
    imem_req = 1'b0; dmem_req = 1'b0; dmem_cmd = SCR1_MEM_CMD_RD;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst.i1_resp", 32'(i1_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    chk("rst.d1_resp", 32'(d1_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    chk("rst.i2_resp", 32'(i2_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    chk("rst.d2_resp", 32'(d2_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    chk("rst.i1_rdata", i1_rdata, 32'h0);
    chk("rst.d1_rdata", d1_rdata, 32'h0);

    // Word, byte and half-word accesses.
    dm_acc("wr_w", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, BASE + 32'h10, 32'hDEADBEEF, SCR1_MEM_RESP_RDY_OK, 32'h0);
    dm_acc("rd_w", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, BASE + 32'h10, 32'h0, SCR1_MEM_RESP_RDY_OK, 32'hDEADBEEF);
    dm_acc("wr_b", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, BASE + 32'h13, 32'h000000A5, SCR1_MEM_RESP_RDY_OK, 32'h0);
    dm_acc("rd_w2", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, BASE + 32'h10, 32'h0, SCR1_MEM_RESP_RDY_OK, 32'hA5ADBEEF);
    dm_acc("rd_h", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, BASE + 32'h12, 32'h0, SCR1_MEM_RESP_RDY_OK, 32'h0000A5AD);

    // Errors: misaligned dmem writes leave memory alone; out-of-window on both ports.
    dm_acc("mis_w", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, BASE + 32'h12, 32'h11111111, SCR1_MEM_RESP_RDY_ER, 32'h0);
    dm_acc("mis_h", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, BASE + 32'h11, 32'h2222, SCR1_MEM_RESP_RDY_ER, 32'h0);
    dm_acc("rd_w3", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, BASE + 32'h10, 32'h0, SCR1_MEM_RESP_RDY_OK, 32'hA5ADBEEF);
    dm_acc("d_oow", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, BASE + SIZE, 32'h0, SCR1_MEM_RESP_RDY_ER, 32'h0);
    im_acc("i_oow", BASE - 32'h4, SCR1_MEM_RESP_RDY_ER, 32'h0);
    im_acc("i_rd", BASE + 32'h10, SCR1_MEM_RESP_RDY_OK, 32'hA5ADBEEF);
    im_acc("i_mis", BASE + 32'h2, SCR1_MEM_RESP_RDY_ER, 32'h0);

    // Arbitration data: BASE+0 and BASE+8 in bank 0, BASE+4 in bank 1.
    dm_acc("pre0", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, BASE + 32'h0, 32'h11223344, SCR1_MEM_RESP_RDY_OK, 32'h0);
    dm_acc("pre4", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, BASE + 32'h4, 32'h99AABBCC, SCR1_MEM_RESP_RDY_OK, 32'h0);
    dm_acc("pre8", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, BASE + 32'h8, 32'h55667788, SCR1_MEM_RESP_RDY_OK, 32'h0);

    // First conflict: dmem wins from reset priority.
    imem_req = 1'b1; imem_addr = BASE;
    dmem_req = 1'b1; dmem_cmd = SCR1_MEM_CMD_RD; dmem_width = SCR1_MEM_WIDTH_WORD; dmem_addr = BASE + 32'h8;
    #1;
    chk("cf1.d_ack", 32'(d1_ack), 32'd1);
    chk("cf1.i_ack", 32'(i1_ack), 32'd0);
    @(posedge clk); #1 dmem_req = 1'b0;
    chk("cf1.i_ack2", 32'(i1_ack), 32'd1);
    @(negedge clk);
    chk("cf1.d_rdata", d1_rdata, 32'h55667788);
    chk("cf1.i_resp0", 32'(i1_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    @(posedge clk); #1 imem_req = 1'b0;
    @(negedge clk);
    chk("cf1.i_resp", 32'(i1_resp), 32'(SCR1_MEM_RESP_RDY_OK));
    chk("cf1.i_rdata", i1_rdata, 32'h11223344);

    // Second conflict: priority has passed to imem.
    imem_req = 1'b1; dmem_req = 1'b1;
    #1;
    chk("cf2.i_ack", 32'(i1_ack), 32'd1);
    chk("cf2.d_ack", 32'(d1_ack), 32'd0);
    @(posedge clk); #1 imem_req = 1'b0;
    chk("cf2.d_ack2", 32'(d1_ack), 32'd1);
    @(negedge clk);
    chk("cf2.i_rdata", i1_rdata, 32'h11223344);
    @(posedge clk); #1 dmem_req = 1'b0;
    @(negedge clk);
    chk("cf2.d_rdata", d1_rdata, 32'h55667788);

    // Different banks: both served together.
    imem_req = 1'b1; imem_addr = BASE; dmem_req = 1'b1; dmem_addr = BASE + 32'h4;
    #1;
    chk("par.i_ack", 32'(i1_ack), 32'd1);
    chk("par.d_ack", 32'(d1_ack), 32'd1);
    @(posedge clk); #1 imem_req = 1'b0; dmem_req = 1'b0;
    @(negedge clk);
    chk("par.i_rdata", i1_rdata, 32'h11223344);
    chk("par.d_rdata", d1_rdata, 32'h99AABBCC);

    // Erroring imem in the same bank as dmem is not a conflict (dmem holds priority).
    imem_req = 1'b1; imem_addr = BASE + 32'h2; dmem_req = 1'b1; dmem_addr = BASE + 32'h8;
    #1;
    chk("erc.i_ack", 32'(i1_ack), 32'd1);
    chk("erc.d_ack", 32'(d1_ack), 32'd1);
    @(posedge clk); #1 imem_req = 1'b0; dmem_req = 1'b0;
    @(negedge clk);
    chk("erc.i_resp", 32'(i1_resp), 32'(SCR1_MEM_RESP_RDY_ER));
    chk("erc.d_rdata", d1_rdata, 32'h55667788);

    // Streaming: 8 back-to-back imem reads, checked on both latencies.
    for (int i = 0; i < 8; i++)
      dm_acc("st_wr", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, BASE + 32'h20 + 32'(4 * i),
             32'hC0DE0000 + 32'(i), SCR1_MEM_RESP_RDY_OK, 32'h0);
    @(posedge clk); #1;
    for (int c = 0; c < 10; c++) begin
      imem_req  = (c < 8);
      imem_addr = BASE + 32'h20 + 32'(4 * c);
      @(negedge clk);
      if (c < 8) chk("st.ack", 32'(i1_ack), 32'd1);
      if (c >= 1 && c <= 8) begin
        chk("st.l1_resp", 32'(i1_resp), 32'(SCR1_MEM_RESP_RDY_OK));
        chk("st.l1_rdata", i1_rdata, 32'hC0DE0000 + 32'(c - 1));
      end
      if (c >= 2) begin
        chk("st.l2_resp", 32'(i2_resp), 32'(SCR1_MEM_RESP_RDY_OK));
        chk("st.l2_rdata", i2_rdata, 32'hC0DE0000 + 32'(c - 2));
      end else begin
        chk("st.l2_idle", 32'(i2_resp), 32'(SCR1_MEM_RESP_NOTRDY));
      end
      @(posedge clk); #1;
    end
    imem_req = 1'b0;

    // Reset with two reads in flight on the 2-cycle instance.
    imem_req = 1'b1; imem_addr = BASE + 32'h20;
    dmem_req = 1'b1; dmem_cmd = SCR1_MEM_CMD_RD; dmem_width = SCR1_MEM_WIDTH_WORD; dmem_addr = BASE + 32'h24;
    #1;
    chk("fl.i_ack", 32'(i1_ack), 32'd1);
    chk("fl.d_ack", 32'(d1_ack), 32'd1);
    @(posedge clk); #1 imem_req = 1'b0; dmem_req = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk("fl.i2_resp", 32'(i2_resp), 32'(SCR1_MEM_RESP_NOTRDY));
      chk("fl.d2_resp", 32'(d2_resp), 32'(SCR1_MEM_RESP_NOTRDY));
      chk("fl.i2_rdata", i2_rdata, 32'h0);
      chk("fl.d2_rdata", d2_rdata, 32'h0);
    end
    im_acc("fl.i_keep", BASE + 32'h20, SCR1_MEM_RESP_RDY_OK, 32'hC0DE0000);
    dm_acc("fl.d_keep", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, BASE + 32'h10, 32'h0, SCR1_MEM_RESP_RDY_OK, 32'hA5ADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
